temp_sample_conditioner: RTL and testbench
==========================================

Name: temp_sample_conditioner

Overview:
- Upstream stage of the thermostat state machine. Accepts raw unsigned temperature samples from the sensor/ADC interface and averages them over a sliding window.
- Saturates the average into the 5-bit temperature range the thermostat FSM consumes, and presents it with a one-cycle valid strobe.
- Detects a stalled sensor through a sample timeout and flags a fault.

Parameters:
- AVG_LOG2, 2, log2 of window depth; window N = 2^AVG_LOG2 samples.
- IN_W, 8, width of raw sample in whole degrees C, unsigned.
- TIMEOUT, 1000, cycles without raw_valid before fault is raised; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- raw_valid  input  1  raw_temp is valid this cycle; one sample accepted per asserted cycle, no backpressure.
- raw_temp  input  IN_W  raw temperature sample.
- temp  output  5  conditioned temperature, 0..31, to thermostat FSM.
- temp_valid  output  1  one-cycle pulse: temp updated.
- ready  output  1  window fully populated; temp reflects a full-window average.
- fault  output  1  sensor timeout flag.

Behaviour:
- Reset (rst=1 at an edge) has these effects:
  - temp=0, temp_valid=0, ready=0, fault=0.
  - Window registers, running sum, fill counter and timeout counter cleared; state=FILL.
  - Reset mid-operation discards all history.
  - rst has priority over raw_valid in the same cycle.
- Storage:
  - N-entry shift window of IN_W bits.
  - Running sum register of IN_W+AVG_LOG2 bits; it never overflows.
  - On an accepted sample: sum_next = sum + raw_temp - oldest; oldest is shifted out and raw_temp shifted in.
- Average and saturation:
  - avg = sum_next >> AVG_LOG2, truncating with no rounding.
  - temp_next = 31 if avg > 31, else avg[4:0].
- State FILL:
  - Each accepted sample is stored and fill count increments; temp and temp_valid are not updated.
  - On the Nth accepted sample: state goes to RUN and ready=1.
  - On that same edge temp=temp_next and temp_valid=1.
- State RUN:
  - Every accepted sample updates temp=temp_next and pulses temp_valid=1 on the accepting edge, so both are visible the cycle after raw_valid (latency 1).
  - temp_valid pulses even if the value is unchanged.
- temp_valid is high for exactly one cycle per update; it is 0 in any cycle following a cycle without an update.
- temp holds its last value at all other times, including after a fault.
- Timeout:
  - The counter resets to 0 on every accepted sample and increments each cycle without raw_valid, saturating at TIMEOUT.
  - The counter reaches TIMEOUT after TIMEOUT consecutive idle cycles. On that edge:
    - fault=1 and ready=0; state goes to FILL.
    - Fill count, window and sum are cleared; temp is held.
  - The timeout counter also runs in FILL.
- Fault clear:
  - fault stays high until the next accepted sample.
  - That sample clears fault on its accepting edge and counts as the first FILL sample.
- Simultaneous events:
  - raw_valid in the cycle the counter would reach TIMEOUT: the sample is accepted, the counter resets, and no fault is raised.
  - raw_valid while fault=1: fault clears and the sample is stored, in the same edge.
- Only N-entry windows with N >= 2 are supported (AVG_LOG2 >= 1).

Test Plan:
- Reset: assert rst 2 cycles with raw_valid=1 and raw_temp=50 -> temp=0, temp_valid=0, ready=0, fault=0; nothing stored.
- Fill: samples 20,20,20,20 on consecutive cycles -> no temp_valid for the first 3; after the 4th, temp=20, temp_valid=1 for 1 cycle, ready=1.
- Sliding average: following the fill, send 28 -> temp=22; then 28 -> temp=24; then 28,28 -> temp=26, then 28. Each gives a single temp_valid pulse one cycle after raw_valid.
- Truncation and saturation:
  - 10,11,11,11 -> temp=10 (sum 43).
  - After reset, 200,200,200,200 -> temp=31.
  - After reset, 30,34,32,31 -> temp=31 (avg 31).
- Timeout (TIMEOUT=8):
  - After a fill to temp=20, hold raw_valid=0 for 8 cycles -> fault=1 on the 8th edge, ready=0, temp stays 20.
  - Next sample 15 -> fault=0; 3 more samples of 15 -> temp=15, ready=1.
- Timeout race (TIMEOUT=8): 7 idle cycles, then raw_valid in the 8th cycle -> fault stays 0 and the counter restarts; a gap of 7 idle cycles repeated indefinitely never raises fault.

Source files
------------

// File: rtl/temp_sample_conditioner.sv
// Sliding-window averager for raw sensor temperatures: saturates the mean into
// the 0..31 range of the thermostat FSM and flags a stalled sensor by timeout.
module temp_sample_conditioner #(
  parameter int AVG_LOG2 = 2,
  parameter int IN_W     = 8,
  parameter int TIMEOUT  = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            raw_valid,
  input  logic [IN_W-1:0] raw_temp,
  output logic [4:0]      temp,
  output logic            temp_valid,
  output logic            ready,
  output logic            fault
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = IN_W + AVG_LOG2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t             state, state_n;
  logic [IN_W-1:0]    win   [N];
  logic [IN_W-1:0]    win_n [N];
  logic [SUM_W-1:0]   sum, sum_n, sum_acc;
  logic [AVG_LOG2-1:0] fill, fill_n;
  logic [CNT_W-1:0]   tcnt, tcnt_n;
  logic [4:0]         temp_p1, temp_n;
  logic               vld_p1, vld_n;
  logic               ready_n, fault_n;

  // Truncating mean of a window sum, clamped to the 5-bit temperature range.
  function automatic logic [4:0] sat5(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] a;
    a = s >> AVG_LOG2;
    if (a > SUM_W'(31)) return 5'd31;
    else                return a[4:0];
  endfunction

  always_comb begin
    state_n = state;
    win_n   = win;
    sum_n   = sum;
    fill_n  = fill;
    tcnt_n  = tcnt;
    temp_n  = temp_p1;
    vld_n   = 1'b0;
    ready_n = ready;
    fault_n = fault;
    sum_acc = sum + SUM_W'(raw_temp) - SUM_W'(win[N-1]);

    if (raw_valid) begin
      // An accepted sample always restarts the timeout and clears any fault.
      tcnt_n  = '0;
      fault_n = 1'b0;
      sum_n   = sum_acc;
      win_n[0] = raw_temp;
      for (int i = 1; i < N; i++) win_n[i] = win[i-1];
      if (state == FILL) begin
        if (fill == AVG_LOG2'(N - 1)) begin
          state_n = RUN;
          ready_n = 1'b1;
          temp_n  = sat5(sum_acc);
          vld_n   = 1'b1;
          fill_n  = '0;
        end else begin
          fill_n = fill + AVG_LOG2'(1);
        end
      end else begin
        temp_n = sat5(sum_acc);
        vld_n  = 1'b1;
      end
    end else if (tcnt != CNT_W'(TIMEOUT)) begin
      tcnt_n = tcnt + CNT_W'(1);
      // Stalled sensor: drop all history but keep the last reported temp.
      if (tcnt == CNT_W'(TIMEOUT - 1)) begin
        fault_n = 1'b1;
        ready_n = 1'b0;
        state_n = FILL;
        fill_n  = '0;
        sum_n   = '0;
        win_n   = '{default: '0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      win     <= '{default: '0};
      sum     <= '0;
      fill    <= '0;
      tcnt    <= '0;
      temp_p1 <= '0;
      vld_p1  <= 1'b0;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_n;
      win     <= win_n;
      sum     <= sum_n;
      fill    <= fill_n;
      tcnt    <= tcnt_n;
      temp_p1 <= temp_n;
      vld_p1  <= vld_n;
      ready   <= ready_n;
      fault   <= fault_n;
    end
  end

  assign temp       = temp_p1;
  assign temp_valid = vld_p1;

endmodule

// File: tb/tb_temp_sample_conditioner.sv
// Randomized and directed checks of temp_sample_conditioner against a
// queue-based reference model of the averaging/timeout behaviour.
module tb_temp_sample_conditioner;

  localparam int AVG_LOG2 = 2;
  localparam int N        = 4;
  localparam int TO       = 8;

  logic       clk = 1'b0;
  logic       rst, raw_valid;
  logic [7:0] raw_temp;
  logic [4:0] temp;
  logic       temp_valid, ready, fault;

  int checks = 0;
  int failures = 0;

  // reference model state
  int   m_q[$];
  logic [4:0] m_temp;
  logic m_vld, m_ready, m_fault;
  int   m_idle;

  temp_sample_conditioner #(.AVG_LOG2(AVG_LOG2), .IN_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .raw_valid(raw_valid), .raw_temp(raw_temp),
    .temp(temp), .temp_valid(temp_valid), .ready(ready), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic model_update(input logic r, input logic v, input int t);
    int s;
    if (r) begin
      m_q.delete(); m_temp = 0; m_vld = 0; m_ready = 0; m_fault = 0; m_idle = 0;
    end else if (v) begin
      m_fault = 0; m_idle = 0; m_vld = 0;
      m_q.push_back(t);
      if (m_q.size() > N) void'(m_q.pop_front());
      if (m_q.size() == N) begin
        s = 0;
        foreach (m_q[i]) s += m_q[i];
        m_temp = (s / N > 31) ? 5'd31 : 5'(s / N);
        m_vld = 1; m_ready = 1;
      end
    end else begin
      m_vld = 0;
      if (m_idle < TO) begin
        m_idle++;
        if (m_idle == TO) begin
          m_fault = 1; m_ready = 0; m_q.delete();
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input int t);
    rst = r; raw_valid = v; raw_temp = 8'(t);
    @(posedge clk);
    model_update(r, v, t);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 50);
      checks++;
      if ({temp, temp_valid, ready, fault} !== 8'h00) begin
        failures++;
        $display("FAIL reset cyc%0d got=%h want=00", i, {temp, temp_valid, ready, fault});
      end
    end
  endtask

  task automatic test_fill;
    step(1, 0, 0);
    for (int i = 0; i < N; i++) begin
      step(0, 1, 20);
      checks++;
      if ({temp, temp_valid, ready, fault} !== {m_temp, m_vld, m_ready, m_fault}) begin
        failures++;
        $display("FAIL fill s%0d got=%h want=%h", i, {temp, temp_valid, ready, fault},
                 {m_temp, m_vld, m_ready, m_fault});
      end
    end
    checks++;
    if (temp !== 5'd20 || temp_valid !== 1'b1 || ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_done got temp=%0d vld=%b rdy=%b want 20/1/1", temp, temp_valid, ready);
    end
  endtask

  task automatic test_sliding;
    int exp_t[4] = '{22, 24, 26, 28};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 28);
      checks++;
      if (temp !== 5'(exp_t[i]) || temp_valid !== 1'b1) begin
        failures++;
        $display("FAIL slide s%0d got temp=%0d vld=%b want %0d/1", i, temp, temp_valid, exp_t[i]);
      end
    end
    step(0, 0, 0);
    checks++;
    if (temp_valid !== 1'b0 || temp !== 5'd28) begin
      failures++;
      $display("FAIL slide_hold got temp=%0d vld=%b want 28/0", temp, temp_valid);
    end
  endtask

  task automatic test_trunc_sat;
    int pat[3][4] = '{'{10, 11, 11, 11}, '{200, 200, 200, 200}, '{30, 34, 32, 31}};
    int want[3] = '{10, 31, 31};
    for (int p = 0; p < 3; p++) begin
      step(1, 0, 0);
      for (int i = 0; i < N; i++) step(0, 1, pat[p][i]);
      checks++;
      if (temp !== 5'(want[p]) || temp_valid !== 1'b1 || temp !== m_temp) begin
        failures++;
        $display("FAIL trunc_sat p%0d got=%0d want=%0d", p, temp, want[p]);
      end
    end
  endtask

  task automatic test_timeout;
    step(1, 0, 0);
    for (int i = 0; i < N; i++) step(0, 1, 20);
    for (int i = 1; i <= TO; i++) begin
      step(0, 0, 0);
      checks++;
      if (fault !== (i == TO) || ready !== (i != TO) || temp !== 5'd20) begin
        failures++;
        $display("FAIL timeout idle%0d got fault=%b rdy=%b temp=%0d", i, fault, ready, temp);
      end
    end
    for (int i = 0; i < N; i++) begin
      step(0, 1, 15);
      checks++;
      if (fault !== 1'b0 || ready !== (i == N - 1) || temp !== ((i == N - 1) ? 5'd15 : 5'd20)) begin
        failures++;
        $display("FAIL refill s%0d got fault=%b rdy=%b temp=%0d", i, fault, ready, temp);
      end
    end
  endtask

  task automatic test_race;
    step(1, 0, 0);
    for (int i = 0; i < N; i++) step(0, 1, 20);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < TO - 1; i++) step(0, 0, 0);
      step(0, 1, 20);
      checks++;
      if (fault !== 1'b0 || ready !== 1'b1 || temp_valid !== 1'b1) begin
        failures++;
        $display("FAIL race r%0d got fault=%b rdy=%b vld=%b want 0/1/1", r, fault, ready, temp_valid);
      end
    end
  endtask

  task automatic test_random;
    int mode, len;
    for (int it = 0; it < 400; it++) begin
      mode = $urandom_range(0, 19);
      if (mode == 0) len = $urandom_range(TO - 2, TO + 3);
      else len = 1;
      for (int k = 0; k < len; k++) begin
        if (mode == 1) step(1, $urandom_range(0, 1), $urandom_range(0, 255));
        else if (mode == 0) step(0, 0, 0);
        else step(0, ($urandom_range(0, 3) != 0), (mode < 6) ? $urandom_range(0, 255)
                                                            : $urandom_range(0, 40));
        checks++;
        if ({temp, temp_valid, ready, fault} !== {m_temp, m_vld, m_ready, m_fault}) begin
          failures++;
          $display("FAIL random it%0d got=%h want=%h", it, {temp, temp_valid, ready, fault},
                   {m_temp, m_vld, m_ready, m_fault});
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; raw_valid = 1'b0; raw_temp = '0;
    m_temp = 0; m_vld = 0; m_ready = 0; m_fault = 0; m_idle = 0;
    #1;
    test_reset;
    test_fill;
    test_sliding;
    test_trunc_sat;
    test_timeout;
    test_race;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
